tcm_dual_port: RTL and testbench
================================

// Module: tcm_dual_port
// PURPOSE
//  Next-generation J2 tightly-coupled memory: NUM_RAM banks of Sky130 2KB 1rw1r SRAM macros.
//  Port 0 (CPU data, MemC/MemR) reads and writes via macro port 0. Port 1 (instruction fetch) is read-only via macro port 1.
//  Adds a registered ack on both ports, same-cycle write->fetch forwarding, and an optional post-reset zero-fill sequencer.
// PARAMETERS
//  AW         15  byte-address width of TCM; AW>=11; NUM_RAM = 2**(AW-11) macros
//  INIT_ZERO  1   1: zero-fill all words after reset before accepting requests; 0: ready right after reset
//  VERBOSE    0   passed to SRAM macro model
// PORTS
//  clk       in   1      system clock, drives all macros
//  rst       in   1      synchronous, active-high reset
//  memc      in   MemC   data port request: sel, wr, a[AW-1:0], be[3:0], d[31:0]
//  memr      out  MemR   data port response: q[31:0]
//  d_ack     out  1      data request accepted in previous cycle; memr.q valid when high and read
//  i_req     in   1      fetch request
//  i_a       in   AW-2   fetch word address
//  i_q       out  32     fetch read data
//  i_ack     out  1      fetch accepted in previous cycle; i_q valid
//  ready     out  1      high when idle/serving; low during reset and zero-fill
// BEHAVIOUR
//  Reset: d_ack=0, i_ack=0, memr.q=0, i_q=0; ready=0 while rst; all macro csb0/csb1=1.
//  FSM (INIT_ZERO=1): INIT -> RUN. INIT: 9-bit counter 0..511 drives all banks' port 0 in parallel:
//    csb0=0, web0=0, wmask0=4'hf, din0=0, addr0=counter; 512 cycles; memc/i_req ignored, no acks.
//    Count 511 written -> RUN next cycle, ready=1. INIT_ZERO=0: enter RUN directly, ready=1 the cycle after rst drops.
//  rst asserted mid-INIT or mid-RUN: counter and FSM return to INIT (or RUN if INIT_ZERO=0) next cycle; in-flight acks dropped (0).
//  RUN, data port: accept when memc.sel & ready. Bank = a[AW-1:11], word = a[10:2].
//    csb0 of bank low only; web0=~wr; wmask0=be; din0=d. d_ack=1 exactly one cycle later, for reads and writes.
//    memr.q = registered-bank-select mux of dout0; 0 if no read accepted last cycle; holds otherwise? no: 0.
//  RUN, fetch port: accept when i_req & ready; bank = i_a[AW-3:9], word = i_a[8:0]; csb1 of bank low.
//    i_ack=1 one cycle later; i_q = selected dout1, 0 if not acked.
//  Forwarding: data write and fetch to the same word in the same cycle -> i_q next cycle = bytes with be=1
//    taken from memc.d, others from dout1 (macro behaviour on collision not relied upon). Registered d/be/hit flag.
//  Different-word or different-bank accesses proceed concurrently with no stall; ports never stall each other.
//  Back-to-back requests: one accepted per port per cycle, full throughput, latency fixed at 1.
//  Sub-word reads return the full 32-bit word; lane extraction is upstream.
// STRUCTURE
//  cpu_pkg: MemC/MemR unchanged; add localparams TCM_BANK_AW=11, TCM_WORD_AW=9 for shared use.
//  Sub-module tcm_bank: one macro plus per-bank csb/addr muxing (INIT vs RUN) and power pins under USE_POWER_PINS.
//  Top: FSM, init counter, bank decode, registered read-select one-hots, forward register, output muxes.
// TESTING
//  INIT: release rst, count cycles -> ready rises after 512+1 cycles; memr/i_q reads of any address = 0.
//  Data RW: write a=0x1004 d=0xDEADBEEF be=f, then read -> d_ack each cycle, memr.q=0xDEADBEEF; be=4'b0011 write 0x1234 -> 0xDEAD1234.
//  Bank crossing (AW=15): write 0x0000=1, 0x0800=2, 0x7FFC=3; fetch words 0x000,0x200,0x1FFF -> i_q 1,2,3.
//  Collision: word 0x40 holds 0x11223344; same cycle write d=0xAABBCCDD be=4'b1010 and fetch same word -> i_q=0xAA22CC44.
//  Concurrent: fetch streams bank 0 while data writes bank 1 every cycle -> both acks high every cycle, no data loss.
//  Reset mid-INIT at count 200 -> ready stays 0, full 512-cycle fill restarts, ready after 513 cycles.

Source files
------------

// File: rtl/tcm_dual_port_pkg.sv
// Shared types for the J2 tightly-coupled memory: CPU data-port bus structs,
// bank geometry constants and the byte-merge helper used by the forwarding path.
package tcm_dual_port_pkg;

    localparam int TCM_BANK_AW = 11;
    localparam int TCM_WORD_AW = 9;

    typedef struct packed {
        logic        sel;
        logic        wr;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } MemC;

    typedef struct packed {
        logic [31:0] q;
    } MemR;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } tcm_state_e;

    // Lanes with be set come from new_d, the rest from old_d.
    function automatic logic [31:0] merge_bytes(input logic [31:0] new_d,
                                                input logic [31:0] old_d,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/tcm_dual_port_bank.sv
// One TCM bank: a 2KB 1rw1r SRAM macro plus the INIT/RUN mux on its control pins.
// The macro below is a cycle-level behavioural stand-in with the Sky130 pinout.
module sky130_sram_2kbyte_1rw1r_32x512_8 #(
    parameter int VERBOSE = 0
) (
`ifdef USE_POWER_PINS
    inout  wire         vccd1,
    inout  wire         vssd1,
`endif
    input  logic        clk0,
    input  logic        csb0,
    input  logic        web0,
    input  logic [3:0]  wmask0,
    input  logic [8:0]  addr0,
    input  logic [31:0] din0,
    output logic [31:0] dout0,
    input  logic        clk1,
    input  logic        csb1,
    input  logic [8:0]  addr1,
    output logic [31:0] dout1
);

    logic [31:0] mem [512];

    if (VERBOSE != 0) begin : g_verbose_unused
    end

    // Port 0: masked byte write, or read into the output register.
    always_ff @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) begin
                for (int i = 0; i < 4; i++) begin
                    if (wmask0[i]) begin
                        mem[addr0][8*i +: 8] <= din0[8*i +: 8];
                    end
                end
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    // Port 1: read-only; returns pre-write contents on a same-word collision.
    always_ff @(posedge clk1) begin
        if (!csb1) begin
            dout1 <= mem[addr1];
        end
    end

endmodule

module tcm_bank import tcm_dual_port_pkg::*; #(
    parameter int VERBOSE = 0
) (
`ifdef USE_POWER_PINS
    inout  wire                   vccd1,
    inout  wire                   vssd1,
`endif
    input  logic                   clk,
    input  logic                   init,
    input  logic [TCM_WORD_AW-1:0] init_addr,
    input  logic                   sel0,
    input  logic                   wr,
    input  logic [3:0]             be,
    input  logic [31:0]            d,
    input  logic [TCM_WORD_AW-1:0] addr0,
    input  logic                   sel1,
    input  logic [TCM_WORD_AW-1:0] addr1,
    output logic [31:0]            dout0,
    output logic [31:0]            dout1
);

    logic                   csb0_s;
    logic                   web0_s;
    logic [3:0]             wmask0_s;
    logic [TCM_WORD_AW-1:0] addr0_s;
    logic [31:0]            din0_s;
    logic                   csb1_s;

    // During zero-fill port 0 is owned by the init counter and port 1 is idle.
    always_comb begin
        csb0_s   = 1'b1;
        web0_s   = 1'b1;
        wmask0_s = 4'h0;
        addr0_s  = '0;
        din0_s   = 32'd0;
        csb1_s   = 1'b1;
        if (init) begin
            csb0_s   = 1'b0;
            web0_s   = 1'b0;
            wmask0_s = 4'hf;
            addr0_s  = init_addr;
            din0_s   = 32'd0;
            csb1_s   = 1'b1;
        end else begin
            csb0_s   = ~sel0;
            web0_s   = ~wr;
            wmask0_s = be;
            addr0_s  = addr0;
            din0_s   = d;
            csb1_s   = ~sel1;
        end
    end

    sky130_sram_2kbyte_1rw1r_32x512_8 #(.VERBOSE(VERBOSE)) u_macro (
`ifdef USE_POWER_PINS
        .vccd1  (vccd1),
        .vssd1  (vssd1),
`endif
        .clk0   (clk),
        .csb0   (csb0_s),
        .web0   (web0_s),
        .wmask0 (wmask0_s),
        .addr0  (addr0_s),
        .din0   (din0_s),
        .dout0  (dout0),
        .clk1   (clk),
        .csb1   (csb1_s),
        .addr1  (addr1),
        .dout1  (dout1)
    );

endmodule

// File: rtl/tcm_dual_port.sv
// Dual-port J2 TCM: data port (read/write) and fetch port (read-only) over
// NUM_RAM banks, fixed 1-cycle latency, write->fetch forwarding, optional zero-fill.
module tcm_dual_port import tcm_dual_port_pkg::*; #(
    parameter int AW        = 15,
    parameter int INIT_ZERO = 1,
    parameter int VERBOSE   = 0
) (
`ifdef USE_POWER_PINS
    inout  wire            vccd1,
    inout  wire            vssd1,
`endif
    input  logic           clk,
    input  logic           rst,
    input  MemC            memc,
    output MemR            memr,
    output logic           d_ack,
    input  logic           i_req,
    input  logic [AW-3:0]  i_a,
    output logic [31:0]    i_q,
    output logic           i_ack,
    output logic           ready
);

    localparam int NUM_RAM = 2 ** (AW - TCM_BANK_AW);
    localparam int BW      = (NUM_RAM > 1) ? (AW - TCM_BANK_AW) : 1;
    localparam tcm_state_e RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

    tcm_state_e             state_r;
    tcm_state_e             next_state_s;
    logic [TCM_WORD_AW-1:0] cnt_r;
    logic                   ready_r;
    logic                   init_s;

    logic                   d_acc_s;
    logic                   i_acc_s;
    logic [BW-1:0]          d_bank_s;
    logic [BW-1:0]          i_bank_s;
    logic [TCM_WORD_AW-1:0] d_word_s;
    logic [TCM_WORD_AW-1:0] i_word_s;
    logic [NUM_RAM-1:0]     d_hot_s;
    logic [NUM_RAM-1:0]     i_hot_s;
    logic                   hit_s;

    logic                   d_ack_r;
    logic                   i_ack_r;
    logic [NUM_RAM-1:0]     rd0_sel_r;
    logic [NUM_RAM-1:0]     rd1_sel_r;
    logic                   fwd_hit_r;
    logic [31:0]            fwd_d_r;
    logic [3:0]             fwd_be_r;

    logic [31:0]            dout0_s [NUM_RAM];
    logic [31:0]            dout1_s [NUM_RAM];
    logic [31:0]            q0_s;
    logic [31:0]            q1_s;
    logic                   unused_s;

    assign unused_s = ^{memc.a[1:0], (memc.a >> AW)};

    // Next-state logic: zero-fill runs until the last word is written.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == 9'd511) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_INIT;
                end
            end
            ST_RUN:  next_state_s = ST_RUN;
            default: next_state_s = RESET_STATE;
        endcase
    end

    // State, init counter and ready register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RESET_STATE;
            cnt_r   <= '0;
            ready_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= (state_r == ST_INIT) ? cnt_r + 9'd1 : 9'd0;
            ready_r <= (next_state_s == ST_RUN);
        end
    end

    assign ready    = ready_r & ~rst;
    assign init_s   = (state_r == ST_INIT) & ~rst;
    assign d_acc_s  = memc.sel & ready;
    assign i_acc_s  = i_req & ready;
    assign d_bank_s = BW'(memc.a[AW-1:0] >> TCM_BANK_AW);
    assign i_bank_s = BW'(i_a >> TCM_WORD_AW);
    assign d_word_s = memc.a[TCM_BANK_AW-1:2];
    assign i_word_s = i_a[TCM_WORD_AW-1:0];
    assign hit_s    = d_acc_s & memc.wr & i_acc_s & (memc.a[AW-1:2] == i_a);

    // Per-bank chip-select one-hots.
    always_comb begin
        d_hot_s = '0;
        i_hot_s = '0;
        for (int b = 0; b < NUM_RAM; b++) begin
            d_hot_s[b] = d_acc_s & (d_bank_s == BW'(b));
            i_hot_s[b] = i_acc_s & (i_bank_s == BW'(b));
        end
    end

    for (genvar b = 0; b < NUM_RAM; b++) begin : g_bank
        tcm_bank #(.VERBOSE(VERBOSE)) u_bank (
`ifdef USE_POWER_PINS
            .vccd1     (vccd1),
            .vssd1     (vssd1),
`endif
            .clk       (clk),
            .init      (init_s),
            .init_addr (cnt_r),
            .sel0      (d_hot_s[b]),
            .wr        (memc.wr),
            .be        (memc.be),
            .d         (memc.d),
            .addr0     (d_word_s),
            .sel1      (i_hot_s[b]),
            .addr1     (i_word_s),
            .dout0     (dout0_s[b]),
            .dout1     (dout1_s[b])
        );
    end

    // Ack, read-select and forwarding registers; only reads steer memr.q.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_ack_r   <= 1'b0;
            i_ack_r   <= 1'b0;
            rd0_sel_r <= '0;
            rd1_sel_r <= '0;
            fwd_hit_r <= 1'b0;
            fwd_d_r   <= 32'd0;
            fwd_be_r  <= 4'h0;
        end else begin
            d_ack_r   <= d_acc_s;
            i_ack_r   <= i_acc_s;
            rd0_sel_r <= d_hot_s & {NUM_RAM{~memc.wr}};
            rd1_sel_r <= i_hot_s;
            fwd_hit_r <= hit_s;
            fwd_d_r   <= memc.d;
            fwd_be_r  <= memc.be;
        end
    end

    // AND-OR read muxes; zero when no bank was selected last cycle.
    always_comb begin
        q0_s = 32'd0;
        q1_s = 32'd0;
        for (int b = 0; b < NUM_RAM; b++) begin
            q0_s = q0_s | (dout0_s[b] & {32{rd0_sel_r[b]}});
            q1_s = q1_s | (dout1_s[b] & {32{rd1_sel_r[b]}});
        end
    end

    assign d_ack  = d_ack_r;
    assign i_ack  = i_ack_r;
    assign memr.q = q0_s;
    assign i_q    = fwd_hit_r ? merge_bytes(fwd_d_r, q1_s, fwd_be_r) : q1_s;

endmodule

// File: tb/tb_tcm_dual_port.sv
// Directed self-checking bench for tcm_dual_port (AW=15, INIT_ZERO=1).
module tb_tcm_dual_port;
    import tcm_dual_port_pkg::*;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst;
    MemC           memc;
    MemR           memr;
    logic          d_ack;
    logic          i_req;
    logic [AW-3:0] i_a;
    logic [31:0]   i_q;
    logic          i_ack;
    logic          ready;

    int checks = 0;
    int errors = 0;
    int ncyc;

    logic [31:0]   bx_a [3] = '{32'h0000_0000, 32'h0000_0800, 32'h0000_7FFC};
    logic [AW-3:0] bx_w [3] = '{13'h0000, 13'h0200, 13'h1FFF};

    always #5 clk = ~clk;

    tcm_dual_port #(.AW(AW), .INIT_ZERO(1), .VERBOSE(0)) dut (
        .clk   (clk),
        .rst   (rst),
        .memc  (memc),
        .memr  (memr),
        .d_ack (d_ack),
        .i_req (i_req),
        .i_a   (i_a),
        .i_q   (i_q),
        .i_ack (i_ack),
        .ready (ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic dreq(input logic sel, input logic wr, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d);
        memc.sel = sel;
        memc.wr  = wr;
        memc.a   = a;
        memc.be  = be;
        memc.d   = d;
    endtask

    task automatic freq(input logic req, input logic [AW-3:0] a);
        i_req = req;
        i_a   = a;
    endtask

    task automatic idle();
        dreq(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
        freq(1'b0, '0);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 600) begin
            step();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();
        step(); step(); step();
        check("rst_ready", ready, 32'd0);
        check("rst_d_ack", d_ack, 32'd0);
        check("rst_i_ack", i_ack, 32'd0);
        check("rst_memr_q", memr.q, 32'd0);
        check("rst_i_q", i_q, 32'd0);

        // Zero-fill: 512 edges after the last reset edge (513 counting it).
        rst = 1'b0;
        wait_ready(ncyc);
        check("init_cycles", ncyc, 32'd512);

        dreq(1'b1, 1'b0, 32'h0000_1004, 4'hf, 32'd0);
        freq(1'b1, 13'h1FFF);
        step();
        check("zf_d_ack", d_ack, 32'd1);
        check("zf_memr", memr.q, 32'd0);
        check("zf_i_ack", i_ack, 32'd1);
        check("zf_i_q", i_q, 32'd0);
        idle();

        dreq(1'b1, 1'b1, 32'h0000_1004, 4'hf, 32'hDEAD_BEEF);
        step();
        check("wr_d_ack", d_ack, 32'd1);
        check("wr_memr_zero", memr.q, 32'd0);
        check("wr_i_ack_idle", i_ack, 32'd0);
        dreq(1'b1, 1'b0, 32'h0000_1004, 4'hf, 32'd0);
        step();
        check("rd_d_ack", d_ack, 32'd1);
        check("rd_memr", memr.q, 32'hDEAD_BEEF);
        dreq(1'b1, 1'b1, 32'h0000_1004, 4'b0011, 32'h0000_1234);
        step();
        dreq(1'b1, 1'b0, 32'h0000_1004, 4'hf, 32'd0);
        step();
        check("be_memr", memr.q, 32'hDEAD_1234);
        idle();
        step();
        check("idle_d_ack", d_ack, 32'd0);

        for (int k = 0; k < 3; k++) begin
            dreq(1'b1, 1'b1, bx_a[k], 4'hf, 32'(k + 1));
            step();
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            freq(1'b1, bx_w[k]);
            step();
            check("bank_i_ack", i_ack, 32'd1);
            check("bank_i_q", i_q, 32'(k + 1));
        end
        idle();

        // Collision: byte 0x100 is word 0x40 of bank 0.
        dreq(1'b1, 1'b1, 32'h0000_0100, 4'hf, 32'h1122_3344);
        step();
        dreq(1'b1, 1'b1, 32'h0000_0100, 4'b1010, 32'hAABB_CCDD);
        freq(1'b1, 13'h0040);
        step();
        check("fwd_i_ack", i_ack, 32'd1);
        check("fwd_i_q", i_q, 32'hAA22_CC44);
        dreq(1'b1, 1'b1, 32'h0000_0104, 4'hf, 32'hFFFF_FFFF);
        freq(1'b1, 13'h0040);
        step();
        check("nofwd_i_q", i_q, 32'hAA22_CC44);
        dreq(1'b1, 1'b0, 32'h0000_0100, 4'hf, 32'd0);
        freq(1'b1, 13'h0040);
        step();
        check("coll_memr", memr.q, 32'hAA22_CC44);
        check("coll_i_q", i_q, 32'hAA22_CC44);
        idle();

        // Fetch streams bank 0 while data writes bank 1.
        for (int k = 0; k < 8; k++) begin
            dreq(1'b1, 1'b1, 32'h0000_0800 + 32'(4 * k), 4'hf, 32'h5000_0000 + 32'(k));
            freq(1'b1, 13'(k));
            step();
            check("conc_d_ack", d_ack, 32'd1);
            check("conc_i_ack", i_ack, 32'd1);
            check("conc_i_q", i_q, (k == 0) ? 32'd1 : 32'd0);
        end
        idle();
        for (int k = 0; k < 8; k++) begin
            dreq(1'b1, 1'b0, 32'h0000_0800 + 32'(4 * k), 4'hf, 32'd0);
            step();
            check("conc_rb", memr.q, 32'h5000_0000 + 32'(k));
        end

        // Request presented in a reset cycle is dropped.
        rst = 1'b1;
        dreq(1'b1, 1'b0, 32'h0000_1004, 4'hf, 32'd0);
        freq(1'b1, 13'h0401);
        step();
        check("rstrun_d_ack", d_ack, 32'd0);
        check("rstrun_i_ack", i_ack, 32'd0);
        check("rstrun_ready", ready, 32'd0);
        rst = 1'b0;
        idle();
        repeat (200) step();
        check("mid_init_ready", ready, 32'd0);
        rst = 1'b1;
        step();
        check("mid_rst_ready", ready, 32'd0);
        rst = 1'b0;
        wait_ready(ncyc);
        check("reinit_cycles", ncyc, 32'd512);
        dreq(1'b1, 1'b0, 32'h0000_1004, 4'hf, 32'd0);
        freq(1'b1, 13'h0401);
        step();
        check("refill_memr", memr.q, 32'd0);
        check("refill_i_q", i_q, 32'd0);
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
